// File: rtl/addsub_arb_pkg.sv
// Shared constants and types for the add/sub round-robin arbiter slice.
// Optional signed-overflow output is enabled by defining ADDSUB_ARB_OVF_EN.
package addsub_arb_pkg;

  localparam int XLEN = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Requester-id width; a one-bit id is kept even for degenerate NREQ.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain 32-bit add/subtract datapath: op=0 gives in1+in2, op=1 gives in1+~in2+1.
module adder
  import addsub_arb_pkg::*;
(
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            op,
  output logic [XLEN-1:0] out
);

  assign out = in1 + (op ? ~in2 : in2) + {{(XLEN-1){1'b0}}, op};

endmodule

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set bit of req_vec_i starting at ptr_i, wrapping mod N.
module rr_priority_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_vec_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  int cand;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_vec_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDW'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among NREQ requesters, with one
// registered result slot. Define ADDSUB_ARB_OVF_EN to register signed overflow in rsp_ovf.
module addsub_rr_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*XLEN-1:0]      req_in1,
  input  logic [NREQ*XLEN-1:0]      req_in2,
  input  logic [NREQ-1:0]           req_type,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic [XLEN-1:0]           rsp_data,
  output logic                      rsp_ovf,
  output logic                      dbg_state
);

  localparam int IDW = id_width(NREQ);

  // Handshake: a transfer happens on any cycle where valid and ready are both high on a
  // channel; the requester holds valid/operands until then, and rsp_* stay stable until
  // rsp_ready is seen with rsp_valid.
  slot_state_e state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  rsp_id_q;
  logic [XLEN-1:0] rsp_data_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            any_req;
  logic            can_accept;
  logic            xfer;
  logic [XLEN-1:0] op_a, op_b, sum;
  logic            op_sub;

  rr_priority_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .req_vec_i (req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .idx_o     (gidx),
    .any_o     (any_req)
  );

  // Draining the slot this cycle frees it for a new load on the same edge.
  assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready;
  assign xfer       = any_req && can_accept;
  assign req_ready  = (rst_n && can_accept) ? grant : '0;

  assign op_a   = req_in1[int'(gidx)*XLEN +: XLEN];
  assign op_b   = req_in2[int'(gidx)*XLEN +: XLEN];
  assign op_sub = req_type[gidx];

  adder u_adder (
    .in1 (op_a),
    .in2 (op_b),
    .op  (op_sub),
    .out (sum)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = SLOT_FULL;
      ptr_d   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end else if (state_q == SLOT_FULL && rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT_EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        rsp_id_q   <= gidx;
        rsp_data_q <= sum;
      end
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = (state_q == SLOT_FULL);

`ifdef ADDSUB_ARB_OVF_EN
  // Subtraction flips B's sign, so one rule covers both ops.
  logic ovf_d, ovf_q;
  assign ovf_d = (op_a[XLEN-1] == (op_b[XLEN-1] ^ op_sub)) && (sum[XLEN-1] != op_a[XLEN-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (xfer) begin
      ovf_q <= ovf_d;
    end
  end

  assign rsp_ovf = ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

endmodule
